// File: rtl/sb_uart_slave.sv
// sb_uart_slave: 8N1 soft UART responder on the 8-bit strobe/ack system bus.
// TX/RX FIFOs, programmable baud divisor, sticky error flags, level irq.
module sb_uart_slave #(
    parameter logic [3:0]  BUS_ADDR74  = 4'b0011,
    parameter int          FIFO_AW     = 2,
    parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wb_stbi,
    input  logic       wb_rwi,
    input  logic [7:0] wb_adri,
    input  logic [7:0] wb_dati,
    output logic [7:0] wb_dato,
    output logic       wb_acko,
    input  logic       rx,
    output logic       tx,
    output logic       irq
);

    localparam int CW = FIFO_AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(1 << FIFO_AW);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic             done, sel, wr, rd;
    logic [3:0]       reg_a;
    logic [7:0]       rd_data, status;
    logic [15:0]      div_r;
    logic [1:0]       irqen;
    logic             txovr, ferr, rxovr;

    logic [7:0]         tx_mem [1 << FIFO_AW];
    logic [FIFO_AW-1:0] tx_wp, tx_rp;
    logic [CW-1:0]      tx_cnt;
    logic               tx_full, tx_empty, tx_busy, tx_push, tx_pop, txovr_set;

    logic [7:0]         rx_mem [1 << FIFO_AW];
    logic [FIFO_AW-1:0] rx_wp, rx_rp;
    logic [CW-1:0]      rx_cnt;
    logic               rx_full, rx_avail, rx_push, rx_pop, rx_done, rxovr_set;
    logic               ferr_set, stat_clr;

    state_t      tx_st, tx_st_n;
    logic [15:0] tx_baud, tx_baud_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_sh, tx_sh_n;

    state_t      rx_st, rx_st_n;
    logic [15:0] rx_baud, rx_baud_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_sh, rx_sh_n;
    logic        rx_m, rx_s, rx_d;

    assign reg_a = wb_adri[3:0];
    assign sel   = wb_stbi & (wb_adri[7:4] == BUS_ADDR74) & ~done;
    assign wr    = sel & wb_rwi;
    assign rd    = sel & ~wb_rwi;

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign tx_busy  = (tx_st != S_IDLE);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_avail = (rx_cnt != '0);

    assign status = {txovr, ferr, rxovr, rx_full,
                     rx_avail, tx_busy, tx_empty, tx_full};

    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign tx_push   = wr & (reg_a == 4'h0) & (~tx_full | tx_pop);
    assign txovr_set = wr & (reg_a == 4'h0) & tx_full & ~tx_pop;
    assign rx_pop    = rd & (reg_a == 4'h0) & rx_avail;
    assign rx_push   = rx_done & (~rx_full | rx_pop);
    assign rxovr_set = rx_done & rx_full & ~rx_pop;
    assign stat_clr  = rd & (reg_a == 4'h1);

    always_comb begin
        rd_data = 8'h00;
        case (reg_a)
            4'h0:    rd_data = rx_avail ? rx_mem[rx_rp] : 8'h00;
            4'h1:    rd_data = status;
            4'h2:    rd_data = div_r[7:0];
            4'h3:    rd_data = div_r[15:8];
            4'h4:    rd_data = {6'b0, irqen};
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_acko <= 1'b0;
            wb_dato <= 8'h00;
            done    <= 1'b0;
            div_r   <= DEFAULT_DIV;
            irqen   <= 2'b00;
            txovr   <= 1'b0;
            ferr    <= 1'b0;
            rxovr   <= 1'b0;
            irq     <= 1'b0;
        end else begin
            wb_acko <= sel;
            wb_dato <= rd ? rd_data : 8'h00;
            done    <= wb_stbi & (done | sel);
            if (wr && reg_a == 4'h2) div_r[7:0]  <= wb_dati;
            if (wr && reg_a == 4'h3) div_r[15:8] <= wb_dati;
            if (wr && reg_a == 4'h4) irqen       <= wb_dati[1:0];
            txovr <= (txovr & ~stat_clr) | txovr_set;
            ferr  <= (ferr  & ~stat_clr) | ferr_set;
            rxovr <= (rxovr & ~stat_clr) | rxovr_set;
            irq   <= (irqen[0] & rx_avail) |
                     (irqen[1] & tx_empty & ~tx_busy);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= wb_dati;
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    always_comb begin
        tx_st_n   = tx_st;
        tx_baud_n = tx_baud;
        tx_bit_n  = tx_bit;
        tx_sh_n   = tx_sh;
        tx_pop    = 1'b0;
        case (tx_st)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    tx_sh_n   = tx_mem[tx_rp];
                    tx_baud_n = div_r;
                    tx_st_n   = S_START;
                end
            end
            S_START: begin
                if (tx_baud == '0) begin
                    tx_baud_n = div_r;
                    tx_bit_n  = 3'd0;
                    tx_st_n   = S_DATA;
                end else begin
                    tx_baud_n = tx_baud - 1'b1;
                end
            end
            S_DATA: begin
                if (tx_baud == '0) begin
                    tx_baud_n = div_r;
                    tx_sh_n   = {1'b0, tx_sh[7:1]};
                    tx_bit_n  = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_st_n = S_STOP;
                end else begin
                    tx_baud_n = tx_baud - 1'b1;
                end
            end
            S_STOP: begin
                if (tx_baud == '0) tx_st_n = S_IDLE;
                else               tx_baud_n = tx_baud - 1'b1;
            end
        endcase
    end

    // Line level decodes straight from state so reset forces idle-high at once
    assign tx = (tx_st == S_START) ? 1'b0 :
                (tx_st == S_DATA)  ? tx_sh[0] : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st   <= S_IDLE;
            tx_baud <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
            rx_st   <= S_IDLE;
            rx_baud <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            tx_st   <= tx_st_n;
            tx_baud <= tx_baud_n;
            tx_bit  <= tx_bit_n;
            tx_sh   <= tx_sh_n;
            rx_st   <= rx_st_n;
            rx_baud <= rx_baud_n;
            rx_bit  <= rx_bit_n;
            rx_sh   <= rx_sh_n;
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_d    <= rx_s;
        end
    end

    always_comb begin
        rx_st_n   = rx_st;
        rx_baud_n = rx_baud;
        rx_bit_n  = rx_bit;
        rx_sh_n   = rx_sh;
        rx_done   = 1'b0;
        ferr_set  = 1'b0;
        case (rx_st)
            S_IDLE: begin
                if (rx_d && !rx_s) begin
                    rx_baud_n = div_r >> 1;
                    rx_st_n   = S_START;
                end
            end
            S_START: begin
                if (rx_baud == '0) begin
                    if (rx_s) begin
                        rx_st_n = S_IDLE;
                    end else begin
                        rx_baud_n = div_r;
                        rx_bit_n  = 3'd0;
                        rx_st_n   = S_DATA;
                    end
                end else begin
                    rx_baud_n = rx_baud - 1'b1;
                end
            end
            S_DATA: begin
                if (rx_baud == '0) begin
                    rx_baud_n = div_r;
                    rx_sh_n   = {rx_s, rx_sh[7:1]};
                    rx_bit_n  = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_st_n = S_STOP;
                end else begin
                    rx_baud_n = rx_baud - 1'b1;
                end
            end
            S_STOP: begin
                if (rx_baud == '0) begin
                    rx_done  = 1'b1;
                    ferr_set = ~rx_s;
                    rx_st_n  = S_IDLE;
                end else begin
                    rx_baud_n = rx_baud - 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sb_uart_slave.sv
// tb_sb_uart_slave: directed bench for sb_uart_slave with a read-data
// scoreboard queue and a per-cycle tx bit queue.
module tb_sb_uart_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_stbi, wb_rwi;
    logic [7:0] wb_adri, wb_dati, wb_dato;
    logic       wb_acko;
    logic       rx_in, tx, irq;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] expq [$];
    logic       txq  [$];

    localparam logic [7:0] A_DATA  = 8'h30;
    localparam logic [7:0] A_STAT  = 8'h31;
    localparam logic [7:0] A_DIVLO = 8'h32;
    localparam logic [7:0] A_DIVHI = 8'h33;
    localparam logic [7:0] A_IRQEN = 8'h34;

    sb_uart_slave dut (
        .clk     (clk),
        .rst     (rst),
        .wb_stbi (wb_stbi),
        .wb_rwi  (wb_rwi),
        .wb_adri (wb_adri),
        .wb_dati (wb_dati),
        .wb_dato (wb_dato),
        .wb_acko (wb_acko),
        .rx      (rx_in),
        .tx      (tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [7:0] e,
                            input string tag);
        expq.push_back(e);
        wb_stbi = 1'b1;
        wb_rwi  = 1'b0;
        wb_adri = a;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ack"}, {7'b0, wb_acko}, 8'h01);
        check(tag, wb_dato, expq.pop_front());
        wb_stbi = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ack_lo"}, {7'b0, wb_acko}, 8'h00);
        check({tag, "_dato_lo"}, wb_dato, 8'h00);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        wb_stbi = 1'b1;
        wb_rwi  = 1'b1;
        wb_adri = a;
        wb_dati = d;
        @(posedge clk);
        @(negedge clk);
        check("wr_ack", {7'b0, wb_acko}, 8'h01);
        check("wr_dato", wb_dato, 8'h00);
        wb_stbi = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stopb);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (4) @(negedge clk);
        end
        rx_in = stopb;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_tx_low(input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, {7'b0, tx}, 8'h00);
    endtask

    initial begin
        int acks;
        logic [7:0] frame;
        rst     = 1'b1;
        wb_stbi = 1'b0;
        wb_rwi  = 1'b0;
        wb_adri = 8'h00;
        wb_dati = 8'h00;
        rx_in   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_tx", {7'b0, tx}, 8'h01);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_ack", {7'b0, wb_acko}, 8'h00);
        check("rst_dato", wb_dato, 8'h00);
        bus_read(A_STAT,  8'h02, "rst_status");
        bus_read(A_DIVLO, 8'h67, "rst_divlo");
        bus_read(A_DIVHI, 8'h00, "rst_divhi");
        bus_read(A_IRQEN, 8'h00, "rst_irqen");
        bus_read(8'h3A,   8'h00, "rsvd_reg");

        bus_write(A_DIVLO, 8'h03);
        bus_write(A_DIVHI, 8'h00);
        bus_read(A_DIVLO, 8'h03, "divlo_rb");
        bus_write(A_DATA, 8'h55);
        wait_tx_low("tx55_start");
        frame = 8'h55;
        repeat (4) txq.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            repeat (4) txq.push_back(frame[b]);
        repeat (4) txq.push_back(1'b1);
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    check("tx55_bit", {7'b0, tx}, {7'b0, txq.pop_front()});
                    @(negedge clk);
                end
            end
            begin
                repeat (2) @(negedge clk);
                repeat (3) bus_read(A_STAT, 8'h06, "tx_busy_status");
            end
        join
        check("tx_idle", {7'b0, tx}, 8'h01);
        @(negedge clk);
        bus_read(A_STAT, 8'h02, "tx_done_status");

        for (int i = 1; i <= 6; i++) bus_write(A_DATA, 8'(i));
        bus_read(A_STAT, 8'h85, "txovr_status");
        bus_read(A_STAT, 8'h05, "txovr_cleared");
        repeat (250) @(negedge clk);
        bus_read(A_STAT, 8'h02, "tx_drained");
        check("tx_drained_line", {7'b0, tx}, 8'h01);

        bus_write(A_IRQEN, 8'h01);
        bus_read(A_IRQEN, 8'h01, "irqen_rb");
        check("irq_quiet", {7'b0, irq}, 8'h00);
        send_byte(8'hA5, 1'b1);
        check("irq_rx", {7'b0, irq}, 8'h01);
        bus_read(A_STAT, 8'h0A, "rxavail_status");
        bus_read(A_DATA, 8'hA5, "rx_a5");
        check("irq_fall", {7'b0, irq}, 8'h00);
        bus_read(A_DATA, 8'h00, "rx_empty_read");

        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        bus_read(A_STAT, 8'h3A, "rxovr_status");
        check("irq_full", {7'b0, irq}, 8'h01);
        bus_read(A_DATA, 8'h11, "rx_11");
        bus_read(A_DATA, 8'h22, "rx_22");
        bus_read(A_DATA, 8'h33, "rx_33");
        bus_read(A_DATA, 8'h44, "rx_44");
        bus_read(A_STAT, 8'h02, "rx_drained");
        send_byte(8'h3C, 1'b0);
        bus_read(A_STAT, 8'h4A, "ferr_status");
        bus_read(A_DATA, 8'h3C, "rx_3c_ferr");
        bus_read(A_STAT, 8'h02, "ferr_cleared");

        wb_stbi = 1'b1;
        wb_rwi  = 1'b0;
        wb_adri = 8'h00;
        repeat (3) begin
            @(negedge clk);
            check("unsel_ack", {7'b0, wb_acko}, 8'h00);
            check("unsel_dato", wb_dato, 8'h00);
        end
        wb_stbi = 1'b0;
        @(negedge clk);

        wb_stbi = 1'b1;
        wb_adri = A_DIVLO;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (wb_acko === 1'b1) acks++;
        end
        check("held_strobe_acks", 8'(acks), 8'h01);
        wb_stbi = 1'b0;
        @(negedge clk);
        @(negedge clk);

        bus_write(A_DATA, 8'hF0);
        bus_write(A_DATA, 8'h0F);
        bus_write(A_DATA, 8'hAA);
        wait_tx_low("rst_mid_start");
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_mid_tx", {7'b0, tx}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_read(A_STAT,  8'h02, "rst_mid_status");
        bus_read(A_DIVLO, 8'h67, "rst_mid_divlo");
        check("rst_mid_line", {7'b0, tx}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sb_uart_slave.md
Name: sb_uart_slave

Overview:
- Soft UART peripheral that acts as a responder on the 8-bit SB-style system bus driven by the team's wishbone master.
- Sits beside the hard SPI/I2C cores on the same strobe/ack bus. Its read data and ack are OR-combined with theirs, so both are held at zero whenever this block is not acknowledging.
- Provides 8N1 TX/RX with FIFOs, a programmable baud divisor and a level interrupt.

Parameters:
- BUS_ADDR74, 4'b0011, value of wb_adri[7:4] that selects this block. Must differ from the hard-IP addresses 0000/0001/0010.
- FIFO_AW, 2, log2 of TX and RX FIFO depth (default depth 4).
- DEFAULT_DIV, 16'd103, reset value of the baud divisor. Bit period = DIV+1 clocks.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wb_stbi  in  1  bus strobe
- wb_rwi  in  1  1=write, 0=read
- wb_adri  in  8  [7:4] block select, [3:0] register
- wb_dati  in  8  write data
- wb_dato  out  8  read data. Zero except in the ack cycle of a read.
- wb_acko  out  1  single-cycle acknowledge
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output, idle high
- irq  out  1  level interrupt

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high (rst).
- Reset values:
  - wb_acko=0, wb_dato=0, tx=1, irq=0.
  - Both FIFOs empty, sticky flags clear.
  - DIV=DEFAULT_DIV, IRQEN=0, TX and RX FSMs in IDLE.
- Handshake:
  - sel = wb_stbi & (wb_adri[7:4]==BUS_ADDR74) & ~done.
  - wb_acko is registered: it is high for exactly one cycle, the cycle after sel.
  - Register side effects occur on the clock edge that raises wb_acko.
  - done sets with ack and clears when wb_stbi is low. A strobe held high is therefore acked only once.
  - Unselected addresses produce no ack and no side effect.
- Register map (wb_adri[3:0]):
  - 0x0 DATA
    - Write pushes into the TX FIFO. If the FIFO is full, the byte is dropped and TXOVR sets.
    - Read pops the RX FIFO. An empty FIFO returns 0x00 with no pop.
  - 0x1 STATUS (read-only)
    - bit0 TXFULL, bit1 TXEMPTY, bit2 TXBUSY, bit3 RXAVAIL, bit4 RXFULL, bit5 RXOVR, bit6 FERR, bit7 TXOVR.
    - Bits 5-7 are sticky. All three clear on the ack of a STATUS read; the value returned is the pre-clear value.
  - 0x2 DIVLO, 0x3 DIVHI: read/write. A new divisor takes effect at the next bit boundary.
  - 0x4 IRQEN: bits[1:0] read/write, bits[7:2] read 0.
  - 0x5-0xF: read 0x00, writes ignored, still acked.
- irq (registered) = (IRQEN[0] & RXAVAIL) | (IRQEN[1] & TXEMPTY & ~TXBUSY).
- TX FSM:
  - States: IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty: pop and load the shifter, go to START. tx=0 for DIV+1 clocks.
  - DATA: 8 bits, LSB first, DIV+1 clocks each.
  - STOP: tx=1 for DIV+1 clocks, then IDLE. The next byte may start on the following cycle, giving back-to-back frames.
  - TXBUSY=1 in any state other than IDLE.
- RX path:
  - rx passes through a 2-flop synchronizer (reset to 1).
  - IDLE: a falling edge starts a half-bit counter (DIV>>1).
  - Mid-start sample:
    - Sample high: return to IDLE (glitch rejected).
    - Sample low: sample 8 data bits at centres spaced DIV+1 clocks apart, then the stop bit.
  - Stop bit 0: set FERR and still push the byte.
  - Push with RX FIFO full: byte dropped, RXOVR set.
- Simultaneous events:
  - A bus pop and an RX push in the same cycle both succeed. Count is unchanged when the FIFO was non-empty.
  - A bus push and a TX pop in the same cycle behave likewise.
- Reset mid-frame: tx returns to 1 immediately (asynchronous) and FIFO contents are lost.

Test Plan:
- Reset, then read all registers:
  - STATUS=0x02, DIVLO=0x67, DIVHI=0x00, IRQEN=0x00.
  - tx=1, irq=0.
  - Each ack is exactly 1 cycle; wb_dato=0 outside the ack cycle.
- Write DIVLO=0x03, DIVHI=0x00, then write DATA=0x55:
  - tx is 0 for 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then 1 for 4 clocks.
  - STATUS bit2 is high throughout the frame.
- With DIV=3, write 6 bytes back-to-back:
  - The first starts transmitting and 4 fill the FIFO.
  - The 6th is dropped. STATUS reads 0x85 (TXFULL, TXBUSY, TXOVR).
  - The next STATUS read shows bit7 clear.
- With DIV=3 and IRQEN=0x01, drive 0xA5 8N1 on rx at 4 clocks/bit:
  - irq rises and STATUS bit3=1.
  - DATA read returns 0xA5, then irq falls and a second DATA read returns 0x00.
- Drive 5 RX bytes without reading: STATUS bit5=1, bit4=1. A frame with stop bit 0 sets bit6.
- Strobe with wb_adri=0x00 (hard SPI address): wb_acko stays 0 and wb_dato stays 0x00. Hold strobe on this block for 5 cycles: exactly one ack.
